ahb_slave_port_mux: RTL and testbench

//  Downstream of the per-slave arbiter: takes its registered one-hot grant and

---
 rtl/ahb_slave_port_mux_pkg.sv | 55 +++++
 rtl/ahb_slave_port_mux_if.sv | 47 ++++
 rtl/ahb_slave_port_mux_onehot.sv | 19 +
 rtl/ahb_slave_port_mux.sv | 113 +++++++++++
 tb/tb_ahb_slave_port_mux.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/ahb_slave_port_mux_pkg.sv
// Shared AHB encodings and payload types for the slave port mux.
package ahb_slave_port_mux_pkg;

  localparam int unsigned HTRANS_W = 2;
  localparam int unsigned HSIZE_W  = 3;
  localparam int unsigned HBURST_W = 3;
  localparam int unsigned HRESP_W  = 2;

  typedef enum logic [HTRANS_W-1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [HBURST_W-1:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [HRESP_W-1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1,
    HRESP_RETRY = 2'd2,
    HRESP_SPLIT = 2'd3
  } hresp_t;

  // Address-phase control carried alongside the address through the mux.
  typedef struct packed {
    htrans_t              htrans;
    logic                 hwrite;
    logic [HSIZE_W-1:0]   hsize;
    hburst_t              hburst;
  } ahb_ctrl_t;

  localparam int unsigned CTRL_W = $bits(ahb_ctrl_t);

  // Response tracking: CANCEL spans the second cycle of a two-cycle response.
  typedef enum logic {
    RESP_NORMAL = 1'b0,
    RESP_CANCEL = 1'b1
  } resp_state_t;

  // True for transfer types that open a data phase.
  function automatic logic is_active(input htrans_t t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_slave_port_mux_if.sv
// Bus bundle between the competing masters, the slave port and the arbiter.
interface ahb_slave_port_mux_if #(
  parameter int unsigned MASTER_NUM = 3,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
);
  logic [MASTER_NUM-1:0]        hgrant;
  logic [MASTER_NUM*ADDR_W-1:0] m_haddr;
  logic [MASTER_NUM*2-1:0]      m_htrans;
  logic [MASTER_NUM-1:0]        m_hwrite;
  logic [MASTER_NUM*3-1:0]      m_hsize;
  logic [MASTER_NUM*3-1:0]      m_hburst;
  logic [MASTER_NUM*DATA_W-1:0] m_hwdata;
  logic [MASTER_NUM-1:0]        m_hready;
  logic [MASTER_NUM*2-1:0]      m_hresp;
  logic [DATA_W-1:0]            m_hrdata;
  logic [ADDR_W-1:0]            s_haddr;
  logic [1:0]                   s_htrans;
  logic                         s_hwrite;
  logic [2:0]                   s_hsize;
  logic [2:0]                   s_hburst;
  logic [DATA_W-1:0]            s_hwdata;
  logic                         s_hready;
  logic [1:0]                   s_hresp;
  logic [DATA_W-1:0]            s_hrdata;
  logic [2:0]                   hburst;
  logic                         hwait;
  logic                         grant_err;

  // View of the port mux itself.
  modport slave (
    input  hgrant, m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hwdata,
    input  s_hready, s_hresp, s_hrdata,
    output m_hready, m_hresp, m_hrdata,
    output s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hwdata,
    output hburst, hwait, grant_err
  );

  // View of the surrounding masters, arbiter and slave.
  modport master (
    output hgrant, m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hwdata,
    output s_hready, s_hresp, s_hrdata,
    input  m_hready, m_hresp, m_hrdata,
    input  s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hwdata,
    input  hburst, hwait, grant_err
  );
endinterface

// File: rtl/ahb_slave_port_mux_onehot.sv
// One-hot select of N lanes of W bits; lowest set index wins, no select gives '0.
module ahb_onehot_mux #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 32
) (
  input  logic [N-1:0]   i_sel,
  input  logic [N*W-1:0] i_data,
  output logic [W-1:0]   o_data_c
);

  // Scan from the top so the lowest set index is the last (winning) assignment.
  always_comb begin
    o_data_c = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (i_sel[i]) o_data_c = i_data[i*W +: W];
    end
  end

endmodule

// File: rtl/ahb_slave_port_mux.sv
// Routes the granted master's address phase to the slave port and tracks the
// data-phase owner one accepted transfer later for HWDATA/HRESP steering.
module ahb_slave_port_mux
  import ahb_slave_port_mux_pkg::*;
#(
  parameter int unsigned MASTER_NUM = 3,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                 hclk,
  input  logic                 hreset,
  ahb_slave_port_mux_if.slave  bus
);

  localparam int unsigned AC_W = ADDR_W + CTRL_W;

  logic [MASTER_NUM*AC_W-1:0] w_m_addr_ctrl;
  logic [AC_W-1:0]            w_addr_ctrl;
  logic [ADDR_W-1:0]          w_haddr;
  ahb_ctrl_t                  w_ctrl;
  htrans_t                    w_eff_htrans;
  logic [MASTER_NUM-1:0]      w_grant_low;
  logic [MASTER_NUM-1:0]      w_data_sel_nxt;
  logic                       w_resp_pending;

  resp_state_t                r_state;
  resp_state_t                w_state_nxt;
  logic [MASTER_NUM-1:0]      r_data_sel;
  logic                       r_grant_err;

  // Pack each master's address and control into one mux lane.
  for (genvar i = 0; i < int'(MASTER_NUM); i++) begin : g_pack
    assign w_m_addr_ctrl[i*AC_W +: AC_W] = {
      bus.m_haddr[i*ADDR_W +: ADDR_W],
      bus.m_htrans[i*2 +: 2],
      bus.m_hwrite[i],
      bus.m_hsize[i*3 +: 3],
      bus.m_hburst[i*3 +: 3]
    };
  end

  ahb_onehot_mux #(.N(MASTER_NUM), .W(AC_W)) u_addr_mux (
    .i_sel    (bus.hgrant),
    .i_data   (w_m_addr_ctrl),
    .o_data_c (w_addr_ctrl)
  );

  ahb_onehot_mux #(.N(MASTER_NUM), .W(DATA_W)) u_wdata_mux (
    .i_sel    (r_data_sel),
    .i_data   (bus.m_hwdata),
    .o_data_c (bus.s_hwdata)
  );

  assign w_haddr = w_addr_ctrl[AC_W-1 -: ADDR_W];
  assign w_ctrl  = ahb_ctrl_t'(w_addr_ctrl[CTRL_W-1:0]);

  // Cancel and reset both suppress the address phase seen by the slave.
  assign w_eff_htrans = (hreset || (r_state == RESP_CANCEL)) ? HTRANS_IDLE : w_ctrl.htrans;

  // Isolate the lowest set grant bit so a multi-hot grant still yields one owner.
  assign w_grant_low    = bus.hgrant & (~bus.hgrant + MASTER_NUM'(1));
  assign w_data_sel_nxt = is_active(w_eff_htrans) ? w_grant_low : '0;

  assign w_resp_pending = (hresp_t'(bus.s_hresp) != HRESP_OKAY) && !bus.s_hready;

  // Slave-side address phase.
  assign bus.s_haddr  = hreset ? '0 : w_haddr;
  assign bus.s_htrans = 2'(w_eff_htrans);
  assign bus.s_hwrite = w_ctrl.hwrite;
  assign bus.s_hsize  = w_ctrl.hsize;
  assign bus.s_hburst = 3'(w_ctrl.hburst);

  // Arbiter feedback.
  assign bus.hburst    = 3'(w_ctrl.hburst);
  assign bus.hwait     = ~bus.s_hready;
  assign bus.grant_err = r_grant_err;

  // Master-side data phase: stalls are broadcast, responses go to the owner only.
  assign bus.m_hready = hreset ? '1 : {MASTER_NUM{bus.s_hready}};
  assign bus.m_hrdata = bus.s_hrdata;
  for (genvar i = 0; i < int'(MASTER_NUM); i++) begin : g_resp
    assign bus.m_hresp[i*2 +: 2] = r_data_sel[i] ? bus.s_hresp : 2'(HRESP_OKAY);
  end

  // Response state register.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) r_state <= RESP_NORMAL;
    else        r_state <= w_state_nxt;
  end

  // Enter CANCEL on the stalled first cycle of a non-OKAY response; leave on ready.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RESP_NORMAL: if (w_resp_pending) w_state_nxt = RESP_CANCEL;
      RESP_CANCEL: if (bus.s_hready)   w_state_nxt = RESP_NORMAL;
      default:                         w_state_nxt = RESP_NORMAL;
    endcase
  end

  // Data-phase owner advances only on accepted cycles.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)            r_data_sel <= '0;
    else if (bus.s_hready) r_data_sel <= w_data_sel_nxt;
  end

  // Sticky flag for an arbiter handing out more than one grant.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)                        r_grant_err <= 1'b0;
    else if ($countones(bus.hgrant) > 1) r_grant_err <= 1'b1;
  end

endmodule

// File: tb/tb_ahb_slave_port_mux.sv
// Directed bench for ahb_slave_port_mux: routing, data-phase ownership, waits,
// two-cycle error cancel, multi-hot grant and mid-transfer reset.
module tb_ahb_slave_port_mux;

  localparam int unsigned MN = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  localparam logic [1:0] T_IDLE = 2'd0, T_NONSEQ = 2'd2, T_SEQ = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR4 = 3'd3;
  localparam logic [1:0] R_OKAY = 2'd0, R_ERROR = 2'd1, R_RETRY = 2'd2;

  logic hclk;
  logic hreset;
  int   n_checks;
  int   n_fail;

  ahb_slave_port_mux_if #(.MASTER_NUM(MN), .ADDR_W(AW), .DATA_W(DW)) bus ();

  ahb_slave_port_mux #(.MASTER_NUM(MN), .ADDR_W(AW), .DATA_W(DW)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Single comparison point for every check in the bench.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_m(input int i, input logic [31:0] addr, input logic [1:0] tr,
                       input logic wr, input logic [2:0] bu);
    bus.m_haddr[i*32 +: 32] = addr;
    bus.m_htrans[i*2 +: 2]  = tr;
    bus.m_hwrite[i]         = wr;
    bus.m_hburst[i*3 +: 3]  = bu;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    hreset        = 1'b1;
    bus.hgrant    = 3'b010;
    bus.m_haddr   = '0;
    bus.m_htrans  = '0;
    bus.m_hwrite  = '0;
    bus.m_hsize   = {3'd2, 3'd2, 3'd2};
    bus.m_hburst  = '0;
    bus.m_hwdata  = {32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    bus.s_hready  = 1'b1;
    bus.s_hresp   = R_OKAY;
    bus.s_hrdata  = '0;
    set_m(1, 32'h1111_0000, T_NONSEQ, 1'b0, B_SINGLE);

    // 1. Reset with a grant driven.
    #2;
    check("rst_htrans",    64'(bus.s_htrans),  64'(T_IDLE));
    check("rst_haddr",     64'(bus.s_haddr),   64'h0);
    check("rst_hready",    64'(bus.m_hready),  64'h7);
    check("rst_grant_err", 64'(bus.grant_err), 64'h0);
    check("rst_hwdata",    64'(bus.s_hwdata),  64'h0);
    check("rst_hresp",     64'(bus.m_hresp),   64'h0);
    tick();
    tick();
    hreset = 1'b0;
    #1;
    check("rel_haddr",  64'(bus.s_haddr),  64'h1111_0000);
    check("rel_htrans", 64'(bus.s_htrans), 64'(T_NONSEQ));
    bus.hgrant = 3'b000;
    #1;
    check("nogrant_htrans", 64'(bus.s_htrans), 64'(T_IDLE));
    check("nogrant_haddr",  64'(bus.s_haddr),  64'h0);
    tick();
    check("idle_hwdata", 64'(bus.s_hwdata), 64'h0);

    // 2. Write from master 0, then read from master 2.
    set_m(0, 32'h0000_0100, T_NONSEQ, 1'b1, B_SINGLE);
    bus.hgrant = 3'b001;
    #1;
    check("m0_haddr",  64'(bus.s_haddr),  64'h100);
    check("m0_hwrite", 64'(bus.s_hwrite), 64'h1);
    tick();
    set_m(2, 32'h0000_0200, T_NONSEQ, 1'b0, B_SINGLE);
    bus.hgrant = 3'b100;
    #1;
    check("m0_dphase_hwdata", 64'(bus.s_hwdata), 64'hD000_0000);
    check("m0_dphase_hresp",  64'(bus.m_hresp),  64'h0);
    check("m2_haddr",         64'(bus.s_haddr),  64'h200);
    check("m2_hwrite",        64'(bus.s_hwrite), 64'h0);
    tick();
    bus.hgrant   = 3'b000;
    bus.s_hrdata = 32'hCAFE_F00D;
    #1;
    check("m2_hrdata",   64'(bus.m_hrdata), 64'hCAFE_F00D);
    check("m2_hwdata",   64'(bus.s_hwdata), 64'hD000_0002);
    check("m2_hresp",    64'(bus.m_hresp),  64'h0);
    check("idle_hburst", 64'(bus.s_hburst), 64'(B_SINGLE));
    tick();

    // 3. INCR4 from master 1 with two wait states on beat 2.
    set_m(1, 32'h0000_0300, T_NONSEQ, 1'b1, B_INCR4);
    bus.hgrant = 3'b010;
    #1;
    check("incr4_hburst",   64'(bus.hburst),   64'(B_INCR4));
    check("incr4_s_hburst", 64'(bus.s_hburst), 64'(B_INCR4));
    tick();
    set_m(1, 32'h0000_0304, T_SEQ, 1'b1, B_INCR4);
    bus.s_hready = 1'b0;
    #1;
    check("wait1_hwait",  64'(bus.hwait),    64'h1);
    check("wait1_hready", 64'(bus.m_hready), 64'h0);
    check("wait1_hwdata", 64'(bus.s_hwdata), 64'hD000_0001);
    tick();
    set_m(0, 32'h0000_0500, T_NONSEQ, 1'b0, B_SINGLE);
    bus.hgrant = 3'b001;
    #1;
    check("wait2_hwait",  64'(bus.hwait),    64'h1);
    check("wait2_hready", 64'(bus.m_hready), 64'h0);
    check("wait2_haddr",  64'(bus.s_haddr),  64'h500);
    check("wait2_hwdata", 64'(bus.s_hwdata), 64'hD000_0001);
    tick();
    bus.hgrant   = 3'b010;
    bus.s_hready = 1'b1;
    #1;
    check("wait_end_hwait",  64'(bus.hwait),    64'h0);
    check("wait_end_hready", 64'(bus.m_hready), 64'h7);
    check("wait_end_hwdata", 64'(bus.s_hwdata), 64'hD000_0001);
    tick();
    bus.hgrant = 3'b000;
    #1;
    check("beat2_hwdata", 64'(bus.s_hwdata), 64'hD000_0001);
    tick();
    check("burst_done_hwdata", 64'(bus.s_hwdata), 64'h0);

    // 4. Two-cycle ERROR on master 1.
    set_m(1, 32'h0000_0400, T_NONSEQ, 1'b1, B_INCR4);
    bus.hgrant = 3'b010;
    tick();
    set_m(1, 32'h0000_0404, T_SEQ, 1'b1, B_INCR4);
    bus.s_hready = 1'b0;
    bus.s_hresp  = R_ERROR;
    #1;
    check("err1_hresp", 64'(bus.m_hresp), 64'h04);
    tick();
    bus.s_hready = 1'b1;
    #1;
    check("err2_hresp",  64'(bus.m_hresp),  64'h04);
    check("err2_htrans", 64'(bus.s_htrans), 64'(T_IDLE));
    tick();
    bus.s_hresp = R_OKAY;
    #1;
    check("post_err_hresp",  64'(bus.m_hresp),  64'h0);
    check("post_err_hwdata", 64'(bus.s_hwdata), 64'h0);
    check("post_err_htrans", 64'(bus.s_htrans), 64'(T_SEQ));
    bus.hgrant = 3'b000;
    tick();

    // 5. Multi-hot grant.
    set_m(0, 32'h0000_0600, T_NONSEQ, 1'b1, B_SINGLE);
    set_m(1, 32'h0000_0700, T_NONSEQ, 1'b1, B_SINGLE);
    bus.hgrant = 3'b011;
    #1;
    check("multi_haddr", 64'(bus.s_haddr), 64'h600);
    tick();
    bus.hgrant = 3'b000;
    #1;
    check("multi_grant_err", 64'(bus.grant_err), 64'h1);
    check("multi_hwdata",    64'(bus.s_hwdata),  64'hD000_0000);
    tick();
    check("sticky_grant_err", 64'(bus.grant_err), 64'h1);

    // 6. Reset during master 2 write data phase.
    set_m(2, 32'h0000_0800, T_NONSEQ, 1'b1, B_SINGLE);
    bus.hgrant = 3'b100;
    tick();
    bus.hgrant  = 3'b000;
    bus.s_hresp = R_RETRY;
    #1;
    check("pre_rst_hwdata", 64'(bus.s_hwdata), 64'hD000_0002);
    check("pre_rst_hresp",  64'(bus.m_hresp),  64'h20);
    hreset = 1'b1;
    #1;
    check("mid_rst_hwdata",    64'(bus.s_hwdata),  64'h0);
    check("mid_rst_hresp",     64'(bus.m_hresp),   64'h0);
    check("mid_rst_grant_err", 64'(bus.grant_err), 64'h0);
    tick();
    hreset      = 1'b0;
    bus.s_hresp = R_OKAY;
    #1;
    check("after_rst_hwdata", 64'(bus.s_hwdata), 64'h0);
    check("after_rst_hready", 64'(bus.m_hready), 64'h7);
    check("after_rst_hresp",  64'(bus.m_hresp),  64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
